mux_serial_sequencer: RTL and testbench

Sequencer that owns the select lines of the 32:1 mux datapath and uses it as a parallel-in, serial-out engine. It latches a 32-bit word, drives the mux data and select inputs, and steps the select through a programmable window of bit positions. The window may wrap from 31 to 0. Each selected bit is presented on a valid/ready stream, with back-pressure, a last-bit flag and a completion pulse. It sits between a word-producing controller and any bit-serial consumer.

---
 rtl/mux_serial_sequencer_if.sv | 35 +++
 rtl/mux_serial_sequencer.sv | 84 ++++++++
 tb/tb_mux_serial_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mux_serial_sequencer_if.sv
// Bundle between the word controller, the 32:1 mux and the bit consumer.
// master: controller/consumer/mux side; slave: the sequencer.
interface mux_serial_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int SELW  = $clog2(WIDTH)
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] word_in;
    logic [SELW-1:0]  first_sel;
    logic [SELW-1:0]  last_sel;
    logic [WIDTH-1:0] mux_a;
    logic [SELW-1:0]  mux_sel;
    logic             mux_y;
    logic             out_valid;
    logic             out_ready;
    logic             out_bit;
    logic             out_last;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, word_in, first_sel, last_sel,
        output out_ready, mux_y,
        input  mux_a, mux_sel, out_valid, out_bit,
        input  out_last, busy, done
    );

    modport slave (
        input  start, abort, word_in, first_sel, last_sel,
        input  out_ready, mux_y,
        output mux_a, mux_sel, out_valid, out_bit,
        output out_last, busy, done
    );
endinterface

// File: rtl/mux_serial_sequencer.sv
// Parallel-in serial-out sequencer driving an external 32:1 mux.
// Ports: clk, rst (async high), bus (slave: start/abort/word, mux, stream).
module mux_serial_sequencer #(
    parameter int WIDTH = 32
) (
    input logic                   clk,
    input logic                   rst,
    mux_serial_sequencer_if.slave bus
);
    localparam int SELW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [SELW-1:0]  sel_q;
    logic [SELW-1:0]  last_q;
    logic             load;
    logic             adv;
    logic             send;
    logic             last;

    assign send = (state_q == SEND);
    assign last = send && (sel_q == last_q);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        adv     = 1'b0;
        // abort wins over start and over a same-cycle handshake
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        load    = 1'b1;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    if (bus.out_ready) begin
                        if (last) state_d = DONE;
                        else      adv     = 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            sel_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                a_q    <= bus.word_in;
                sel_q  <= bus.first_sel;
                last_q <= bus.last_sel;
            end else if (adv) begin
                // natural SELW-bit overflow gives the 31 -> 0 wrap
                sel_q <= sel_q + SELW'(1);
            end
        end
    end

    assign bus.mux_a     = a_q;
    assign bus.mux_sel   = sel_q;
    assign bus.out_valid = send;
    assign bus.out_bit   = bus.mux_y & send;
    assign bus.out_last  = last;
    assign bus.busy      = send;
    assign bus.done      = (state_q == DONE);
endmodule

// File: tb/tb_mux_serial_sequencer.sv
// Directed bench for mux_serial_sequencer with a behavioural 32:1 mux.
// Drives and samples on the falling clock edge.
module tb_mux_serial_sequencer;
    logic clk;
    logic rst;
    int   errs;
    int   checks;

    mux_serial_sequencer_if #(.WIDTH(32)) bus ();

    mux_serial_sequencer #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.mux_y = bus.mux_a[bus.mux_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] W = 32'h865346bd;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // One transfer; stalls of slen cycles before each bit k with smask[k].
    task automatic xfer(input string       tag,
                        input logic [31:0] w,
                        input logic [4:0]  f,
                        input logic [4:0]  l,
                        input int          n,
                        input logic [31:0] exp_bits,
                        input logic [31:0] smask,
                        input int          slen,
                        input int          exp_busy);
        int         nbusy;
        logic [4:0] es;
        nbusy = 0;
        bus.word_in   = w;
        bus.first_sel = f;
        bus.last_sel  = l;
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.word_in = '0;
        for (int k = 0; k < n; k++) begin
            es = f + 5'(k);
            if (smask[k]) begin
                bus.out_ready = 1'b0;
                for (int s = 0; s < slen; s++) begin
                    chk($sformatf("%s stall sel k%0d", tag, k),
                        32'(bus.mux_sel), 32'(es));
                    chk($sformatf("%s stall bit k%0d", tag, k),
                        32'(bus.out_bit), 32'(exp_bits[k]));
                    if (bus.busy) nbusy++;
                    @(negedge clk);
                end
                bus.out_ready = 1'b1;
            end
            chk($sformatf("%s valid k%0d", tag, k),
                32'(bus.out_valid), 32'd1);
            chk($sformatf("%s sel k%0d", tag, k),
                32'(bus.mux_sel), 32'(es));
            chk($sformatf("%s bit k%0d", tag, k),
                32'(bus.out_bit), 32'(exp_bits[k]));
            chk($sformatf("%s last k%0d", tag, k),
                32'(bus.out_last), 32'(k == n - 1));
            chk($sformatf("%s done-lo k%0d", tag, k),
                32'(bus.done), 32'd0);
            if (bus.busy) nbusy++;
            @(negedge clk);
        end
        chk({tag, " done"}, 32'(bus.done), 32'd1);
        chk({tag, " busy-off"}, 32'(bus.busy), 32'd0);
        chk({tag, " busy cycles"}, 32'(nbusy), 32'(exp_busy));
        @(negedge clk);
        chk({tag, " done pulse"}, 32'(bus.done), 32'd0);
        chk({tag, " idle"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        errs          = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.word_in   = '0;
        bus.first_sel = '0;
        bus.last_sel  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst valid", 32'(bus.out_valid), 32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst sel", 32'(bus.mux_sel), 32'd0);
        chk("rst a", bus.mux_a, 32'd0);
        chk("rst last", 32'(bus.out_last), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // basic: bits 1,0,1,1,1,1,0,1
        xfer("basic", W, 5'd0, 5'd7, 8, 32'h000000bd, '0, 0, 8);
        // wrap: sel 30,31,0,1 -> bits 0,1,1,0
        xfer("wrap", W, 5'd30, 5'd1, 4, 32'h00000006, '0, 0, 4);
        // full: 32 bits from 5 round to 4
        xfer("full", W, 5'd5, 5'd4, 32, {W[4:0], W[31:5]}, '0, 0, 32);
        chk("full end sel", 32'(bus.mux_sel), 32'd4);
        // single bit at 31
        xfer("single", W, 5'd31, 5'd31, 1, 32'h00000001, '0, 0, 1);
        // back-pressure on 2nd and 5th bits, 3 cycles each
        xfer("bp", W, 5'd0, 5'd7, 8, 32'h000000bd, 32'h12, 3, 14);

        // start ignored in SEND, then abort during bit 3
        bus.word_in   = W;
        bus.first_sel = 5'd0;
        bus.last_sel  = 5'd7;
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.word_in   = 32'h0;
        bus.first_sel = 5'd20;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ign start a", bus.mux_a, W);
        chk("ign start sel", 32'(bus.mux_sel), 32'd1);
        chk("ign start busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk("abort pre sel", 32'(bus.mux_sel), 32'd2);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort valid", 32'(bus.out_valid), 32'd0);
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        chk("abort sel", 32'(bus.mux_sel), 32'd2);
        chk("abort a", bus.mux_a, W);
        @(negedge clk);
        chk("abort no done", 32'(bus.done), 32'd0);

        // abort and start together in IDLE
        bus.first_sel = 5'd9;
        bus.word_in   = 32'h12345678;
        bus.start     = 1'b1;
        bus.abort     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("abort+start busy", 32'(bus.busy), 32'd0);
        chk("abort+start sel", 32'(bus.mux_sel), 32'd2);
        chk("abort+start a", bus.mux_a, W);

        // async reset mid-SEND with an all-ones word
        bus.word_in   = 32'hffffffff;
        bus.first_sel = 5'd3;
        bus.last_sel  = 5'd20;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("pre-rst busy", 32'(bus.busy), 32'd1);
        chk("pre-rst bit", 32'(bus.out_bit), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst valid", 32'(bus.out_valid), 32'd0);
        chk("arst busy", 32'(bus.busy), 32'd0);
        chk("arst done", 32'(bus.done), 32'd0);
        chk("arst sel", 32'(bus.mux_sel), 32'd0);
        chk("arst a", bus.mux_a, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst idle", 32'(bus.busy), 32'd0);
        chk("post-rst valid", 32'(bus.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
